mxu_pe: RTL and testbench
=========================

// Module: mxu_pe
// PURPOSE
//  - One processing element (PE) of the systolic matrix-multiply unit (MXU).
//  - Holds a 4-entry recirculating weight delay line, loaded via a forwarded load bus.
//  - Computes signed act*weight + partial_sum each cycle.
//  - Forwards load signals one hop (registered) and returns activation on a 4-stage backward path.
// PARAMETERS
//  - Y_INDEX   default 8'd0   row index of this PE; weights load only when load_weight_target_y == Y_INDEX
// PORTS
//  - clk                       in   1   sole clock, rising edge
//  - rst                       in   1   synchronous, active-high reset
//  - load_phase                in   1   weight-load phase flag
//  - load_weight_target_y      in   8   row targeted by load_weight
//  - load_weight               in   8   weight to load (signed two's complement)
//  - activation                in   8   signed activation
//  - partial_sum               in   24  signed incoming partial sum
//  - result                    out  24  signed MAC result
//  - phase_out                 out  1   load_phase delayed 1 cycle
//  - load_weight_target_y_out  out  8   load_weight_target_y delayed 1 cycle
//  - weight_out                out  8   load_weight delayed 1 cycle
//  - activation_out_bw         out  8   activation delayed 4 cycles
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - every register clears to 0, including outputs, the 4 weight-memory entries and the activation pipe.
//    - Reset mid-operation discards loaded weights.
//  - Forward path: phase_out, load_weight_target_y_out and weight_out are plain registers, 1-cycle latency.
//    - Inputs are forwarded regardless of Y_INDEX.
//  - Weight delay line: 4 registers m0->m1->m2->m3; tail m3 = weight_mem_out.
//    - Every cycle the line shifts.
//    - Load (load_phase=1 AND load_weight_target_y==Y_INDEX): m0 <= load_weight.
//    - Otherwise: m0 <= m3 (recirculate).
//    - After 4 load cycles w0..w3, the tail reads w0,w1,w2,w3,w0,... on successive cycles.
//    - Load with a target mismatch leaves the contents rotating, unchanged.
//  - Activation backward path: activation -> s1 -> s2 -> s3 -> activation_out_bw.
//    - All four are registers; latency exactly 4 cycles; independent of load_phase.
//  - MAC, 2-cycle latency:
//    - Edge k: s1 <= activation; w1 <= weight_mem_out (pre-edge tail); p1 <= partial_sum.
//    - Edge k+1: result <= sext24(s1*w1) + p1.
//    - Arithmetic: 8x8 signed multiply -> 16-bit product, sign-extended to 24 bits.
//    - 24-bit add wraps modulo 2^24.
//  - The MAC runs every cycle, including during load phase.
//    - During load phase result is computed with whatever the tail holds; consumers ignore it.
//  - The activation applied in the cycle right after the last load cycle multiplies w0, the next w1, and so on.
// CONFIGURATION
//  - MXU_PE_SATURATE_EN defined:
//    - the final add uses signed saturation instead of wrap;
//    - clamps to 24'h7FFFFF / 24'h800000 on overflow.
//  - Not defined: wrap-around modulo 2^24.
//  - Identical behaviour in both modes when no overflow occurs.
// TESTING
//  - Forward: load_phase=1,tgt=5,w=10 then 0,6,20.
//    - Next edge: outputs 1/5/10.
//    - Following edge: 0/6/20.
//  - Backward: activation 99,100,101,102 on consecutive edges -> activation_out_bw = 99,100,101,102 on edges 4..7.
//  - Delay line (Y_INDEX=5): load 10,20,30,40 with tgt=5, then load_phase=0, load_weight=1.
//    - Tail reads 10,20,30,40,10,20,30,40.
//    - No contamination by the value 1.
//  - Target mismatch: load 10..40 with tgt=5, then load_phase=1, tgt=6, w=77 for 4 cycles -> tail still cycles 10,20,30,40.
//  - MAC: after loading 10..40, activation 10,20,0xE2,0 with partial_sum=1.
//    - Result two edges later: 101, 401, 24'hFFFC7D, 1.
//  - Overflow: w=127, act=127, partial_sum=24'h7FFFFF.
//    - Wrap build: 24'h803F00.
//    - With MXU_PE_SATURATE_EN: 24'h7FFFFF.
//    - Then rst mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/mxu_pe.sv
// mxu_pe: systolic MXU processing element (weight delay line, signed MAC, load forwarding, activation return path).
// Define MXU_PE_SATURATE_EN for a saturating final add; the default build wraps modulo 2^24.
module mxu_pe #(
    parameter logic [7:0] Y_INDEX = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_phase,
    input  logic [7:0]  load_weight_target_y,
    input  logic [7:0]  load_weight,
    input  logic [7:0]  activation,
    input  logic [23:0] partial_sum,
    output logic [23:0] result,
    output logic        phase_out,
    output logic [7:0]  load_weight_target_y_out,
    output logic [7:0]  weight_out,
    output logic [7:0]  activation_out_bw
);
    logic signed [7:0] m0, m1, m2, m3, s1, s2, s3, w1;
    logic [23:0] p1;
    logic signed [15:0] prod;
    logic [24:0] sum;
    logic [23:0] acc;
    logic load;
    assign load = load_phase && (load_weight_target_y == Y_INDEX);
    assign prod = s1 * w1;
    // One guard bit so the sign disagreement of sum[24] and sum[23] flags overflow
    assign sum = {{9{prod[15]}}, prod} + {p1[23], p1};
`ifdef MXU_PE_SATURATE_EN
    assign acc = (sum[24] ^ sum[23]) ? {sum[24], {23{~sum[24]}}} : sum[23:0];
`else
    assign acc = sum[23:0];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            {m0, m1, m2, m3, s1, s2, s3, w1} <= '0;
            p1 <= '0;
            result <= '0;
            phase_out <= 1'b0;
            load_weight_target_y_out <= '0;
            weight_out <= '0;
            activation_out_bw <= '0;
        end else begin
            m0 <= load ? load_weight : m3;
            m1 <= m0;
            m2 <= m1;
            m3 <= m2;
            s1 <= activation;
            s2 <= s1;
            s3 <= s2;
            activation_out_bw <= s3;
            w1 <= m3;
            p1 <= partial_sum;
            result <= acc;
            phase_out <= load_phase;
            load_weight_target_y_out <= load_weight_target_y;
            weight_out <= load_weight;
        end
    end
endmodule

// File: tb/tb_mxu_pe.sv
// tb_mxu_pe: directed and random stimulus for mxu_pe (Y_INDEX=5) against a queue/arithmetic reference model.
module tb_mxu_pe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_phase = 1'b0;
    logic [7:0]  load_weight_target_y = '0;
    logic [7:0]  load_weight = '0;
    logic [7:0]  activation = '0;
    logic [23:0] partial_sum = '0;
    logic [23:0] result;
    logic        phase_out;
    logic [7:0]  load_weight_target_y_out;
    logic [7:0]  weight_out;
    logic [7:0]  activation_out_bw;

    int total = 0;
    int passed = 0;

    // Reference state: weight line as a queue (front = tail), activation history, pending MAC result
    int wq[$];
    int aq[$];
    logic [23:0] pend, e_res;
    logic        e_phase;
    logic [7:0]  e_tgt, e_w, e_bw;

    mxu_pe #(.Y_INDEX(8'd5)) dut (
        .clk(clk),
        .rst(rst),
        .load_phase(load_phase),
        .load_weight_target_y(load_weight_target_y),
        .load_weight(load_weight),
        .activation(activation),
        .partial_sum(partial_sum),
        .result(result),
        .phase_out(phase_out),
        .load_weight_target_y_out(load_weight_target_y_out),
        .weight_out(weight_out),
        .activation_out_bw(activation_out_bw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [23:0] mac(input logic [7:0] a, input int w, input logic [23:0] ps);
        int s;
        s = int'($signed(a)) * w + int'($signed(ps));
`ifdef MXU_PE_SATURATE_EN
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
`endif
        return s[23:0];
    endfunction

    task automatic model_reset();
        wq = '{0, 0, 0, 0};
        aq = '{0, 0, 0};
        pend = '0;
        e_res = '0;
        e_phase = 1'b0;
        e_tgt = '0;
        e_w = '0;
        e_bw = '0;
    endtask

    task automatic tick();
        int nw;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            e_res = pend;
            pend = mac(activation, wq[0], partial_sum);
            nw = (load_phase && load_weight_target_y == 8'd5) ? int'($signed(load_weight)) : wq[0];
            void'(wq.pop_front());
            wq.push_back(nw);
            aq.push_back(int'(activation));
            e_bw = 8'(aq.pop_front());
            e_phase = load_phase;
            e_tgt = load_weight_target_y;
            e_w = load_weight;
        end
        #1;
        chk("result", result, e_res);
        chk("phase_out", 24'(phase_out), 24'(e_phase));
        chk("tgt_out", 24'(load_weight_target_y_out), 24'(e_tgt));
        chk("weight_out", 24'(weight_out), 24'(e_w));
        chk("act_bw", 24'(activation_out_bw), 24'(e_bw));
    endtask

    task automatic drive(input logic lp, input logic [7:0] tgt, input logic [7:0] w,
                         input logic [7:0] a, input logic [23:0] ps);
        load_phase = lp;
        load_weight_target_y = tgt;
        load_weight = w;
        activation = a;
        partial_sum = ps;
    endtask

    task automatic load4(input logic [7:0] tgt, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
        drive(1, tgt, w0, 0, 0); tick();
        drive(1, tgt, w1, 0, 0); tick();
        drive(1, tgt, w2, 0, 0); tick();
        drive(1, tgt, w3, 0, 0); tick();
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        chk("reset_result", result, 24'h0);
        rst = 1'b0;
        // Forward path
        drive(1, 5, 10, 0, 0); tick();
        chk("fwd1", {15'd0, phase_out, load_weight_target_y_out}, {15'd0, 1'b1, 8'd5});
        drive(0, 6, 20, 0, 0); tick();
        chk("fwd2_w", 24'(weight_out), 24'd20);
        // Backward path
        rst = 1'b1; drive(0, 0, 0, 0, 0); tick(); rst = 1'b0;
        drive(0, 0, 0, 99, 0); tick();
        drive(0, 0, 0, 100, 0); tick();
        drive(0, 0, 0, 101, 0); tick();
        drive(0, 0, 0, 102, 0); tick();
        chk("bw99", 24'(activation_out_bw), 24'd99);
        drive(0, 0, 0, 0, 0); tick(); tick(); tick();
        chk("bw102", 24'(activation_out_bw), 24'd102);
        // Delay line observed through result with act=1, ps=0
        load4(5, 10, 20, 30, 40);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1, 0); tick();
        end
        chk("line_tail", result, 24'd30);
        // Target mismatch keeps rotating contents
        for (int i = 0; i < 4; i++) begin
            drive(1, 6, 77, 1, 0); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0); tick();
        end
        // MAC directed: reload so the next activation meets w0
        rst = 1'b1; drive(0, 0, 0, 0, 0); tick(); rst = 1'b0;
        load4(5, 10, 20, 30, 40);
        drive(0, 0, 0, 10, 1); tick();
        drive(0, 0, 0, 20, 1); tick();
        chk("mac101", result, 24'd101);
        drive(0, 0, 0, 8'hE2, 1); tick();
        chk("mac401", result, 24'd401);
        drive(0, 0, 0, 0, 1); tick();
        chk("mac_neg", result, 24'hFFFC7D);
        drive(0, 0, 0, 0, 0); tick();
        chk("mac1", result, 24'd1);
        // Overflow
        load4(5, 127, 127, 127, 127);
        drive(0, 0, 0, 127, 24'h7FFFFF); tick();
        drive(0, 0, 0, 0, 0); tick();
`ifdef MXU_PE_SATURATE_EN
        chk("ovf", result, 24'h7FFFFF);
`else
        chk("ovf", result, 24'h803F00);
`endif
        // Reset mid-run clears everything
        drive(1, 5, 55, 33, 24'h123456); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst", {result[15:0], activation_out_bw}, 24'h0);
        // Random traffic, occasional loads and resets
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) != 0) ? 8'd5 : 8'($urandom),
                  8'($urandom), 8'($urandom), 24'($urandom));
            tick();
        end
        rst = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
